// File: rtl/clksw_pkg.sv
// Shared definitions for the clock-switch sequencer: FSM states, reserved codes
// and the supported-format table checked when CLKSW_CODE_CHECK_EN is defined.
package clksw_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUTE   = 3'd1,
    GATE   = 3'd2,
    LOAD   = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } clksw_state_e;

  localparam logic [7:0] CLKSW_CODE_STOP = 8'hFF;
  localparam logic [7:0] CLKSW_CODE_DSD  = 8'h80;

  localparam int CLKSW_NUM_CODES = 20;
  localparam logic [7:0] CLKSW_SUPPORTED [CLKSW_NUM_CODES] = '{
    8'h00, 8'h20, 8'h40, 8'h04, 8'h24, 8'h44, 8'h01, 8'h21, 8'h41, 8'h02,
    8'h22, 8'h42, 8'h03, 8'h23, 8'h43, 8'h05, 8'h25, 8'h45,
    CLKSW_CODE_DSD, CLKSW_CODE_STOP
  };

  function automatic logic clksw_code_valid(input logic [7:0] code);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < CLKSW_NUM_CODES; i++) begin
      if (CLKSW_SUPPORTED[i] == code) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/clksw_down_counter.sv
// Loadable down-counter shared by the mute, gap and settle waits; saturates at 0.
module clksw_down_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/clock_switch_seq.sv
// Format-change sequencer: mute, park selector on stop code, load new code, settle, unmute.
// Optional macro CLKSW_CODE_CHECK_EN rejects unsupported codes with fmt_err.
module clock_switch_seq
  import clksw_pkg::*;
#(
  parameter int MUTE_CYCLES   = 256,
  parameter int GAP_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CNT_W         = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fmt_req,
  input  logic [7:0] fmt_code,
  output logic       fmt_ack,
  output logic       fmt_err,
  output logic       busy,
  output logic       mute,
  output logic [7:0] sel_code,
  output logic       sel_load,
  output logic [7:0] cur_fmt
);

  clksw_state_e     state;
  logic [7:0]       req_code;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  clksw_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Counter is loaded with N-1 as each timed state is entered.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_load = fmt_req;
        cnt_val  = CNT_W'(MUTE_CYCLES - 1);
      end
      MUTE: begin
        cnt_load = cnt_zero;
        cnt_val  = CNT_W'(GAP_CYCLES - 1);
        cnt_dec  = !cnt_zero;
      end
      GATE:   cnt_dec = !cnt_zero;
      LOAD: begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(SETTLE_CYCLES - 1);
      end
      SETTLE: cnt_dec = !cnt_zero;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_code <= CLKSW_CODE_STOP;
      sel_code <= CLKSW_CODE_STOP;
      sel_load <= 1'b0;
      mute     <= 1'b1;
      busy     <= 1'b0;
      fmt_ack  <= 1'b0;
      cur_fmt  <= CLKSW_CODE_STOP;
`ifdef CLKSW_CODE_CHECK_EN
      fmt_err  <= 1'b0;
`endif
    end else begin
      sel_load <= 1'b0;
      fmt_ack  <= 1'b0;
`ifdef CLKSW_CODE_CHECK_EN
      fmt_err  <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (fmt_req) begin
            req_code <= fmt_code;
            busy     <= 1'b1;
`ifdef CLKSW_CODE_CHECK_EN
            if (!clksw_code_valid(fmt_code)) begin
              state   <= DONE;
              fmt_ack <= 1'b1;
              fmt_err <= 1'b1;
            end else
`endif
            if (fmt_code == cur_fmt && cur_fmt != CLKSW_CODE_STOP) begin
              state   <= DONE;
              fmt_ack <= 1'b1;
            end else begin
              state <= MUTE;
              mute  <= 1'b1;
            end
          end
        end
        MUTE: begin
          if (cnt_zero) begin
            state    <= GATE;
            sel_code <= CLKSW_CODE_STOP;
            sel_load <= 1'b1;
          end
        end
        GATE: begin
          if (cnt_zero) begin
            if (req_code == CLKSW_CODE_STOP) begin
              state   <= DONE;
              fmt_ack <= 1'b1;
              cur_fmt <= req_code;
            end else begin
              state    <= LOAD;
              sel_code <= req_code;
              sel_load <= 1'b1;
            end
          end
        end
        LOAD: state <= SETTLE;
        SETTLE: begin
          if (cnt_zero) begin
            state   <= DONE;
            fmt_ack <= 1'b1;
            cur_fmt <= req_code;
            mute    <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef CLKSW_CODE_CHECK_EN
  assign fmt_err = 1'b0;
`endif

endmodule

// File: tb/tb_clock_switch_seq.sv
// Directed bench for clock_switch_seq with M=4, G=2, S=8; honours CLKSW_CODE_CHECK_EN.
module tb_clock_switch_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       fmt_req;
  logic [7:0] fmt_code;
  logic       fmt_ack;
  logic       fmt_err;
  logic       busy;
  logic       mute;
  logic [7:0] sel_code;
  logic       sel_load;
  logic [7:0] cur_fmt;

  int vectors = 0;
  int errors  = 0;

  clock_switch_seq #(
    .MUTE_CYCLES   (4),
    .GAP_CYCLES    (2),
    .SETTLE_CYCLES (8),
    .CNT_W         (12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fmt_req  (fmt_req),
    .fmt_code (fmt_code),
    .fmt_ack  (fmt_ack),
    .fmt_err  (fmt_err),
    .busy     (busy),
    .mute     (mute),
    .sel_code (sel_code),
    .sel_load (sel_load),
    .cur_fmt  (cur_fmt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request in the current cycle and step through cycles 0..ack_cyc.
  // alt_code is driven onto fmt_code at cycle 3 to prove mid-sequence changes are ignored.
  task automatic run_seq(input logic [7:0] code, input int ack_cyc, input bit load_new,
                         input bit mute_after, input logic [7:0] alt_code);
    fmt_code = code;
    fmt_req  = 1'b1;
    for (int c = 0; c <= ack_cyc; c++) begin
      tick();
      if (c == 3) fmt_code = alt_code;
      chk($sformatf("busy c%0d", c), busy, 1'b1);
      chk($sformatf("sel_load c%0d", c), sel_load, (c == 4) || (load_new && c == 6));
      chk($sformatf("fmt_ack c%0d", c), fmt_ack, c == ack_cyc);
      chk($sformatf("fmt_err c%0d", c), fmt_err, 1'b0);
      chk($sformatf("mute c%0d", c), mute, (c < ack_cyc) ? 1'b1 : mute_after);
      if (c == 4 || c == 5) chk($sformatf("sel_code c%0d", c), sel_code, 8'hFF);
      if (c == 6 && load_new) chk("sel_code load", sel_code, code);
    end
    chk("sel_code hold", sel_code, load_new ? code : 8'hFF);
    chk("cur_fmt", cur_fmt, code);
  endtask

  task automatic drop_req();
    fmt_req = 1'b0;
    tick();
    chk("idle busy", busy, 1'b0);
    chk("idle ack", fmt_ack, 1'b0);
  endtask

  task automatic chk_reset_vals();
    chk("rst sel_code", sel_code, 8'hFF);
    chk("rst sel_load", sel_load, 1'b0);
    chk("rst mute", mute, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst ack", fmt_ack, 1'b0);
    chk("rst err", fmt_err, 1'b0);
    chk("rst cur_fmt", cur_fmt, 8'hFF);
  endtask

  initial begin
    rst      = 1'b1;
    fmt_req  = 1'b0;
    fmt_code = 8'h00;
    #12;
    chk_reset_vals();
    rst = 1'b0;
    tick();

    // Full switch to 0x01.
    run_seq(8'h01, 15, 1'b1, 1'b0, 8'h01);
    drop_req();

    // Same code again takes the fast path.
    fmt_code = 8'h01;
    fmt_req  = 1'b1;
    tick();
    chk("fast ack", fmt_ack, 1'b1);
    chk("fast sel_load", sel_load, 1'b0);
    chk("fast mute", mute, 1'b0);
    chk("fast busy", busy, 1'b1);
    drop_req();
    chk("fast no load", sel_load, 1'b0);

    // Play 0x45, then stop with 0xFF.
    run_seq(8'h45, 15, 1'b1, 1'b0, 8'h45);
    drop_req();
    run_seq(8'hFF, 6, 1'b0, 1'b1, 8'hFF);
    drop_req();
    chk("stop mute held", mute, 1'b1);

    // Reset in cycle 7 of a 0x22 switch.
    fmt_code = 8'h22;
    fmt_req  = 1'b1;
    for (int c = 0; c <= 7; c++) tick();
    chk("pre-rst busy", busy, 1'b1);
    rst     = 1'b1;
    fmt_req = 1'b0;
    #1;
    chk_reset_vals();
    tick();
    rst = 1'b0;
    tick();
    run_seq(8'h22, 15, 1'b1, 1'b0, 8'h22);
    drop_req();

    // fmt_code toggles mid-switch; fmt_req held through ack.
    run_seq(8'h02, 15, 1'b1, 1'b0, 8'h80);
    tick();
    chk("reaccept idle busy", busy, 1'b0);
    chk("reaccept idle ack", fmt_ack, 1'b0);
    run_seq(8'h80, 15, 1'b1, 1'b0, 8'h80);
    drop_req();

    // Unsupported code 0x07.
`ifdef CLKSW_CODE_CHECK_EN
    fmt_code = 8'h07;
    fmt_req  = 1'b1;
    tick();
    chk("bad ack", fmt_ack, 1'b1);
    chk("bad err", fmt_err, 1'b1);
    chk("bad sel_load", sel_load, 1'b0);
    chk("bad cur_fmt", cur_fmt, 8'h80);
    chk("bad mute", mute, 1'b0);
    chk("bad sel_code", sel_code, 8'h80);
    drop_req();
    chk("bad err clear", fmt_err, 1'b0);
`else
    run_seq(8'h07, 15, 1'b1, 1'b0, 8'h07);
    drop_req();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
